va_pixel_shifter: RTL

- Video output stage directly downstream of the 1801VP1-037 video address/DRAM controller.
- Captures the 16-bit DRAM video word on the WTI strobe into a holding register, then double-buffers it into a 2-bit-per-clock shift register.
- Produces mono pixel pairs or a 2-bit colour index with RGB decode, blanks when no word was fetched, and delays the composite sync to stay aligned with the pixel pipeline.

---
 rtl/va_pixel_shifter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/va_pixel_shifter.sv
// -----------------------------------------------------------------------------
// va_pixel_shifter
//
// Video output stage that sits directly behind the video address / DRAM
// controller. Each fetched 16-bit video word arrives on PIN_D together with a
// one-clock PIN_WTI strobe. It is captured into a holding register and then
// double-buffered into a 16-bit shift register that delivers one 2-bit pair
// per clock, least-significant pair first. A registered output stage turns
// each pair into either a mono pixel pair or a 2-bit colour index with RGB
// decode. The composite sync is delayed so it stays aligned with the pixels.
//
// Timing: a WTI sampled at edge t reloads the phase counter with WTI_PHASE.
// The transfer into the shift register happens at edge t+6, and pixel k
// (k = 0..7) is on the outputs after edge t+7+k.
//
// Parameters
//   WTI_PHASE      phase-counter value loaded on a WTI edge (default 2)
//   SYNC_DLY       number of flip-flops in the sync delay line, 1..15 (default 7)
//
// Optional build macro
//   VA_SHIFT_BORDER_EN  when defined, blanked words drive PIN_BORDER onto RGB.
//                       When undefined, blank RGB is 000 and PIN_BORDER is
//                       ignored.
//
// Ports
//   PIN_CLK        in   1   pixel/2 clock, rising edge
//   PIN_R          in   1   asynchronous active-high reset
//   PIN_WTI        in   1   video word strobe, one clock per fetched word
//   PIN_D          in  16   DRAM read data, valid while PIN_WTI = 1
//   PIN_COLOR      in   1   1 = 4-colour mode, 0 = mono
//   PIN_nVSYNC_IN  in   1   composite sync, active-low
//   PIN_BORDER     in   3   border RGB (optional feature only)
//   PIN_PIX        out  2   mono pixel pair or colour index
//   PIN_R_OUT      out  1   decoded red
//   PIN_G_OUT      out  1   decoded green
//   PIN_B_OUT      out  1   decoded blue
//   PIN_nSYNC_OUT  out  1   delayed composite sync, active-low
// -----------------------------------------------------------------------------
module va_pixel_shifter #(
    parameter int WTI_PHASE = 2,
    parameter int SYNC_DLY  = 7
) (
    input  logic        PIN_CLK,
    input  logic        PIN_R,
    input  logic        PIN_WTI,
    input  logic [15:0] PIN_D,
    input  logic        PIN_COLOR,
    input  logic        PIN_nVSYNC_IN,
    input  logic [2:0]  PIN_BORDER,
    output logic [1:0]  PIN_PIX,
    output logic        PIN_R_OUT,
    output logic        PIN_G_OUT,
    output logic        PIN_B_OUT,
    output logic        PIN_nSYNC_OUT
);

    localparam logic [2:0] PH_LOAD = 3'(WTI_PHASE);

    // Pipeline state.
    logic [2:0]          ph_q,   ph_d;
    logic [15:0]         hold_q, hold_d;
    logic                hv_q,   hv_d;
    logic [15:0]         sr_q,   sr_d;
    logic                sv_q,   sv_d;
    logic [1:0]          pix_q,  pix_d;
    logic [2:0]          rgb_q,  rgb_d;
    logic [SYNC_DLY-1:0] sync_q, sync_d;

    logic                xfer_s;
    logic [2:0]          blank_rgb_s;

    // Colour used while no valid word is in the shift register.
`ifdef VA_SHIFT_BORDER_EN
    assign blank_rgb_s = PIN_BORDER;
`else
    // The border input is read but masked off, so blanking is always black.
    assign blank_rgb_s = PIN_BORDER & 3'b000;
`endif

    // Transfer happens on the edge where the phase counter is at its last slot.
    assign xfer_s = (ph_q == 3'd7);

    // Phase counter, holding register and shift register next state.
    always_comb begin
        ph_d   = ph_q + 3'd1;
        hold_d = hold_q;
        hv_d   = hv_q;
        sr_d   = {2'b00, sr_q[15:2]};
        sv_d   = sv_q;

        // A WTI re-syncs the phase immediately, even at an irregular phase.
        if (PIN_WTI) begin
            ph_d = PH_LOAD;
        end else begin
            ph_d = ph_q + 3'd1;
        end

        // The holding register is consumed by a transfer; a WTI on the same
        // edge refills it, so the valid flag stays set in that case.
        if (PIN_WTI) begin
            hold_d = PIN_D;
            hv_d   = 1'b1;
        end else if (xfer_s) begin
            hold_d = hold_q;
            hv_d   = 1'b0;
        end else begin
            hold_d = hold_q;
            hv_d   = hv_q;
        end

        // Transfer takes the holding register as it was before this edge.
        if (xfer_s) begin
            sr_d = hv_q ? hold_q : 16'h0000;
            sv_d = hv_q;
        end else begin
            sr_d = {2'b00, sr_q[15:2]};
            sv_d = sv_q;
        end
    end

    // Pixel decode from the pair currently at the bottom of the shift register.
    always_comb begin
        pix_d = 2'b00;
        rgb_d = 3'b000;
        if (sv_q) begin
            pix_d = sr_q[1:0];
            if (PIN_COLOR) begin
                case (sr_q[1:0])
                    2'b00:   rgb_d = 3'b000;
                    2'b01:   rgb_d = 3'b001;
                    2'b10:   rgb_d = 3'b010;
                    2'b11:   rgb_d = 3'b100;
                    default: rgb_d = 3'b000;
                endcase
            end else begin
                // Mono: the low bit of the pair drives white/black.
                rgb_d = {3{sr_q[0]}};
            end
        end else begin
            pix_d = 2'b00;
            rgb_d = blank_rgb_s;
        end
    end

    // Sync delay line: stage 0 samples the input, the last stage is the output.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = PIN_nVSYNC_IN;
        for (int i = 1; i < SYNC_DLY; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge PIN_CLK or posedge PIN_R) begin
        if (PIN_R) begin
            ph_q   <= 3'd0;
            hold_q <= 16'h0000;
            hv_q   <= 1'b0;
            sr_q   <= 16'h0000;
            sv_q   <= 1'b0;
            pix_q  <= 2'b00;
            rgb_q  <= 3'b000;
            sync_q <= {SYNC_DLY{1'b1}};
        end else begin
            ph_q   <= ph_d;
            hold_q <= hold_d;
            hv_q   <= hv_d;
            sr_q   <= sr_d;
            sv_q   <= sv_d;
            pix_q  <= pix_d;
            rgb_q  <= rgb_d;
            sync_q <= sync_d;
        end
    end

    assign PIN_PIX       = pix_q;
    assign PIN_R_OUT     = rgb_q[2];
    assign PIN_G_OUT     = rgb_q[1];
    assign PIN_B_OUT     = rgb_q[0];
    assign PIN_nSYNC_OUT = sync_q[SYNC_DLY-1];

endmodule
